// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch stage: the fetch state
// encoding, the byte offset between consecutive instruction words, the
// word-alignment mask, and a helper that flags misaligned targets.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // Byte distance between sequential instructions.
  localparam int unsigned WORD_OFFSET = 32'd4;
  // Number of byte-offset bits dropped to form a word address.
  localparam int unsigned WORD_SHIFT  = $clog2(WORD_OFFSET);
  // Low PC bits that must be zero for a word-aligned address.
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;

  // True when the byte-offset bits of an address are not word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return ((low_bits & ALIGN_MASK) != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage between the program counter and decode. Requests the word at
// the current PC from instruction memory (req/ack), captures the returned
// instruction together with its PC and offers the pair to decode
// (valid/ready). Drives the PC increment/load controls and handles
// branch/jump redirects from execute, including draining a memory request
// that was already in flight when the redirect arrived.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   pc_value          current PC from the program counter
//   pc_increment      PC += 4 at the next edge (combinational)
//   pc_load           PC <= pc_target at the next edge (combinational)
//   pc_target         word-aligned redirect target (combinational)
//   imem_req/addr     memory request and word address, held until ack
//   imem_ack/rdata    memory read data valid / instruction word
//   redirect(_pc)     taken branch/jump and its target, from execute
//   instr_valid/ready decode handshake
//   instr, instr_pc   fetched instruction and its PC (registered)
//   align_fault       sticky flag: a redirect target was misaligned
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int IMEM_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      pc_value,
  output logic                       pc_increment,
  output logic                       pc_load,
  output logic [DATA_WIDTH-1:0]      pc_target,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_WIDTH-1:0]      imem_rdata,
  input  logic                       redirect,
  input  logic [DATA_WIDTH-1:0]      redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [DATA_WIDTH-1:0]      instr,
  output logic [DATA_WIDTH-1:0]      instr_pc,
  output logic                       align_fault
);

  fetch_state_e               state_r;
  fetch_state_e               state_next_s;
  logic [IMEM_ADDR_WIDTH-1:0] drain_addr_r;
  logic [IMEM_ADDR_WIDTH-1:0] fetch_addr_s;
  logic [DATA_WIDTH-1:0]      aligned_target_s;
  logic                       capture_s;
  logic                       clear_valid_s;
  logic                       drain_capture_s;
  logic                       fault_set_s;

  // Word address of the current PC and the word-aligned redirect target.
  assign fetch_addr_s     = pc_value[IMEM_ADDR_WIDTH+WORD_SHIFT-1:WORD_SHIFT];
  assign aligned_target_s = {redirect_pc[DATA_WIDTH-1:2], redirect_pc[1:0] & ~ALIGN_MASK};

  // Next-state logic plus all combinational outputs and register enables.
  always_comb begin
    state_next_s    = state_r;
    imem_req        = 1'b0;
    imem_addr       = {IMEM_ADDR_WIDTH{1'b0}};
    pc_increment    = 1'b0;
    pc_load         = 1'b0;
    pc_target       = {DATA_WIDTH{1'b0}};
    capture_s       = 1'b0;
    clear_valid_s   = 1'b0;
    drain_capture_s = 1'b0;
    fault_set_s     = 1'b0;

    // A redirect outranks everything except the start-up IDLE cycle.
    if (redirect && (state_r != ST_IDLE)) begin
      pc_load       = 1'b1;
      pc_target     = aligned_target_s;
      clear_valid_s = 1'b1;
      fault_set_s   = is_misaligned(redirect_pc[1:0]);
    end else begin
      pc_load = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = fetch_addr_s;
        if (redirect) begin
          // An unacknowledged request cannot be withdrawn: remember its
          // address so it can be completed and its data thrown away.
          if (imem_ack) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s    = ST_DRAIN;
            drain_capture_s = 1'b1;
          end
        end else if (imem_ack) begin
          capture_s    = 1'b1;
          pc_increment = 1'b1;
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        // A redirect drops the held word even if decode would take it.
        if (redirect || instr_ready) begin
          clear_valid_s = 1'b1;
          state_next_s  = ST_FETCH;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_r;
        if (imem_ack) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Fetch state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Captured instruction, its PC and the decode valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr       <= {DATA_WIDTH{1'b0}};
      instr_pc    <= {DATA_WIDTH{1'b0}};
      instr_valid <= 1'b0;
    end else if (capture_s) begin
      instr       <= imem_rdata;
      instr_pc    <= pc_value;
      instr_valid <= 1'b1;
    end else if (clear_valid_s) begin
      instr_valid <= 1'b0;
    end
  end

  // Address of the abandoned request, held for the whole drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_addr_r <= {IMEM_ADDR_WIDTH{1'b0}};
    end else if (drain_capture_s) begin
      drain_addr_r <= fetch_addr_s;
    end
  end

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_fault <= 1'b0;
    end else if (fault_set_s) begin
      align_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Randomized bench: a memory responder with random latency, a program
// counter model driven by the DUT controls, random decode back-pressure and
// random redirects. Items expected at decode are queued when memory returns
// them and discarded on redirects; a monitor pops on every decode handshake.
// An architectural PC stream (sequential +4, jumps on redirect) is checked
// independently.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] pc_value;
  logic          pc_increment;
  logic          pc_load;
  logic [DW-1:0] pc_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = 32'd0;
  logic          redirect = 1'b0;
  logic [DW-1:0] redirect_pc = 32'd0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr;
  logic [DW-1:0] instr_pc;
  logic          align_fault;

  instr_fetch_unit #(.DATA_WIDTH(DW), .IMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .pc_value(pc_value),
    .pc_increment(pc_increment), .pc_load(pc_load), .pc_target(pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       q[$];
  logic [31:0] mem [0:255];
  int          n_tests = 0;
  int          n_fail = 0;

  // stimulus controls
  int ready_pct = 70;
  int redir_pct = 8;
  bit misalign_en = 1'b0;
  bit zero_wait = 1'b0;

  // environment state
  int unsigned cyc;
  bit          exp_valid;
  bit          fault_exp;
  bit          in_req = 1'b0;
  int          lat_left = 0;
  bit          drain_pending = 1'b0;
  bit          draining_now = 1'b0;
  logic [31:0] arch_pc = 32'd0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [7:0]  prev_addr = 8'd0;
  int          accept_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_instr_valid"}, instr_valid, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
    check({tag, "_align_fault"}, align_fault, 32'd0);
    check({tag, "_imem_req"}, imem_req, 32'd0);
    check({tag, "_pc_increment"}, pc_increment, 32'd0);
    check({tag, "_pc_load"}, pc_load, 32'd0);
    check({tag, "_pc_target"}, pc_target, 32'd0);
  endtask

  // Program counter, cycle count since reset, expected valid and fault.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_value  <= 32'd0;
      cyc       <= 0;
      exp_valid <= 1'b0;
      fault_exp <= 1'b0;
    end else begin
      if (pc_load) pc_value <= pc_target;
      else if (pc_increment) pc_value <= pc_value + 32'd4;
      if (cyc < 32'd1000000) cyc <= cyc + 1;
      exp_valid <= (q.size() != 0);
      if (redirect && cyc >= 1 && redirect_pc[1:0] != 2'b00) fault_exp <= 1'b1;
    end
  end

  // Driver: decode ready, redirects, memory responder; pushes expectations.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      in_req = 1'b0; drain_pending = 1'b0; draining_now = 1'b0;
      imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    end else begin
      instr_ready = ($urandom_range(0, 99) < ready_pct);
      redirect    = (cyc >= 1) && ($urandom_range(0, 99) < redir_pct);
      redirect_pc = misalign_en ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if (imem_req) begin
        if (!in_req) begin
          in_req   = 1'b1;
          lat_left = zero_wait ? 0 : int'($urandom_range(0, 3));
        end
        if (lat_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          in_req     = 1'b0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          lat_left--;
        end
      end else begin
        imem_ack = 1'b0;
        in_req   = 1'b0;
      end
      draining_now = drain_pending;
      if (redirect) begin
        q.delete();
        if (imem_req && !imem_ack) drain_pending = 1'b1;
        else if (imem_ack) drain_pending = 1'b0;
      end else if (imem_ack) begin
        if (!drain_pending) q.push_back({pc_value, mem[pc_value[9:2]]});
        drain_pending = 1'b0;
      end
    end
  end

  // Monitor: settles two time units after the driver, compares against models.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      arch_pc  = 32'd0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      automatic bit redir_ok = redirect && (cyc >= 1);
      check("valid_vs_model", instr_valid, exp_valid);
      check("inc_load_excl", pc_increment & pc_load, 32'd0);
      check("pc_increment", pc_increment, imem_ack && !draining_now && !redir_ok);
      if (cyc == 0) check("idle_no_req", imem_req, 32'd0);
      if (cyc == 1) begin
        check("first_req", imem_req, 32'd1);
        check("first_addr", imem_addr, 32'd0);
      end
      if (redir_ok) begin
        check("pc_load_on_redirect", pc_load, 32'd1);
        check("pc_target", pc_target, redirect_pc & 32'hFFFF_FFFC);
      end else begin
        check("pc_load_idle", pc_load, 32'd0);
      end
      if (instr_valid) check("hold_no_req", imem_req, 32'd0);
      if (instr_valid && instr_ready && !redir_ok) begin
        accept_cnt++;
        if (q.size() == 0) begin
          check("unexpected_instr", 32'd1, 32'd0);
        end else begin
          automatic item_t e = q.pop_front();
          check("instr", instr, e.ins);
          check("instr_pc", instr_pc, e.pc);
        end
        check("arch_pc", instr_pc, arch_pc);
        arch_pc = arch_pc + 32'd4;
      end
      if (redir_ok) arch_pc = redirect_pc & 32'hFFFF_FFFC;
      if (prev_req && !prev_ack) begin
        check("req_held", imem_req, 32'd1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (imem_req && !draining_now) check("imem_addr", imem_addr, pc_value[9:2]);
      check("align_fault", align_fault, fault_exp);
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  // Test sequence.
  initial begin
    bit found;
    int a0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    #1;
    check_reset_values("rst");
    @(posedge clk); #2; reset = 1'b0;

    // aligned redirects, random back-pressure and latency
    repeat (400) @(negedge clk);
    // misaligned redirect targets allowed
    misalign_en = 1'b1;
    repeat (300) @(negedge clk);

    // zero-wait memory, decode always ready: one instruction per 2 cycles
    misalign_en = 1'b0; redir_pct = 0; ready_pct = 100; zero_wait = 1'b1;
    repeat (10) @(negedge clk);
    #4; a0 = accept_cnt;
    repeat (20) @(negedge clk);
    #4; check("throughput", accept_cnt - a0, 32'd10);

    // reset while draining an abandoned request
    zero_wait = 1'b0; ready_pct = 60; redir_pct = 15;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk); #3;
      if (draining_now) found = 1'b1;
    end
    check("drain_reached", found, 32'd1);
    if (found) begin
      reset = 1'b1;
      #1;
      check_reset_values("rst_drain");
      repeat (2) @(posedge clk);
      #2; reset = 1'b0;
    end
    repeat (300) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
